// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin line arbiter between the instruction cache (line reads) and the
// data cache (line reads and writes). It is the only master of the RAM line
// bus and runs one transaction at a time.
//
// Build option: define MEM_ARB_TIMEOUT_EN to enable a watchdog that ends a
// READ/WRITE after TIMEOUT_CYCLES without a RAM response, returning a valid
// pulse qualified by the error flag. Without it, transactions wait forever
// and the error outputs are tied low.
//
// Handshake contract:
//   Requester side: raise req with address (and direction/wdata for dcache)
//   stable, hold it until the one-cycle valid pulse. A req still high in the
//   cycle after valid is a new request.
//   Bus side: o_mem_read/o_mem_write stay high until i_mem_ready/i_mem_done is
//   sampled high; the arbiter then waits until both have fallen before it
//   grants again, so a stale response is never mistaken for the next one.
//
// Debug: o_debug_state exposes the FSM state (0 IDLE, 1 READ, 2 WRITE,
// 3 RELEASE).

module mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LINE_BITS      = 256,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  i_clock,
    input  logic                  i_reset,

    input  logic                  i_icache_req,
    input  logic [ADDR_WIDTH-1:0] i_icache_address,
    output logic                  o_icache_valid,
    output logic [LINE_BITS-1:0]  o_icache_data,
    output logic                  o_icache_error,

    input  logic                  i_dcache_req,
    input  logic                  i_dcache_write,
    input  logic [ADDR_WIDTH-1:0] i_dcache_address,
    input  logic [LINE_BITS-1:0]  i_dcache_wdata,
    output logic                  o_dcache_valid,
    output logic [LINE_BITS-1:0]  o_dcache_rdata,
    output logic                  o_dcache_error,

    output logic [ADDR_WIDTH-1:0] o_mem_address,
    output logic                  o_mem_read,
    output logic                  o_mem_write,
    inout  wire  [LINE_BITS-1:0]  io_mem_data,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_done,

    output logic [1:0]            o_debug_state
);

    // Byte offset bits inside one line; the bus address is always line aligned.
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;

    // Round-robin pointer: 1 when the data cache was granted last.
    logic                  last_dcache_q;
    logic                  last_dcache_d;
    // Owner of the transaction in flight: 1 = data cache.
    logic                  grant_dcache_q;
    logic                  grant_dcache_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LINE_BITS-1:0]  wdata_q;
    logic [LINE_BITS-1:0]  wdata_d;

    logic                  mem_read_q;
    logic                  mem_read_d;
    logic                  mem_write_q;
    logic                  mem_write_d;

    logic                  ic_valid_q;
    logic                  ic_valid_d;
    logic [LINE_BITS-1:0]  ic_data_q;
    logic [LINE_BITS-1:0]  ic_data_d;
    logic                  dc_valid_q;
    logic                  dc_valid_d;
    logic [LINE_BITS-1:0]  dc_data_q;
    logic [LINE_BITS-1:0]  dc_data_d;

    logic                  any_req;
    logic                  pick_dcache;
    logic                  timeout_hit;

    // Arbitration: a lone request wins; on a tie the side not granted last wins.
    assign any_req     = i_icache_req | i_dcache_req;
    assign pick_dcache = i_dcache_req & (~i_icache_req | ~last_dcache_q);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q;
    logic               ic_error_q;
    logic               ic_error_d;
    logic               dc_error_q;
    logic               dc_error_d;

    // Watchdog counts cycles spent in READ/WRITE; it is zero on entry.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            timer_q <= '0;
        end else if (state_q == ST_READ || state_q == ST_WRITE) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
        end
    end

    assign timeout_hit = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Error flags are registered alongside the valid pulses they qualify.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            ic_error_q <= 1'b0;
            dc_error_q <= 1'b0;
        end else begin
            ic_error_q <= ic_error_d;
            dc_error_q <= dc_error_d;
        end
    end

    assign o_icache_error = ic_error_q;
    assign o_dcache_error = dc_error_q;
`else
    assign timeout_hit    = 1'b0;
    assign o_icache_error = 1'b0;
    assign o_dcache_error = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = (pick_dcache && i_dcache_write) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (i_mem_ready || timeout_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_WRITE: begin
                if (i_mem_done || timeout_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!i_mem_ready && !i_mem_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath logic: next values for every registered output.
    always_comb begin
        last_dcache_d  = last_dcache_q;
        grant_dcache_d = grant_dcache_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        ic_data_d      = ic_data_q;
        dc_data_d      = dc_data_q;
        ic_valid_d     = 1'b0;
        dc_valid_d     = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        ic_error_d     = 1'b0;
        dc_error_d     = 1'b0;
`endif
        // Strobes follow the state being entered, so they rise with the grant
        // and fall on the edge that sees the response.
        mem_read_d     = (state_d == ST_READ);
        mem_write_d    = (state_d == ST_WRITE);

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    last_dcache_d  = pick_dcache;
                    grant_dcache_d = pick_dcache;
                    addr_d         = pick_dcache ? i_dcache_address : i_icache_address;
                    if (pick_dcache && i_dcache_write) begin
                        wdata_d = i_dcache_wdata;
                    end
                end
            end
            ST_READ: begin
                if (i_mem_ready) begin
                    if (grant_dcache_q) begin
                        dc_valid_d = 1'b1;
                        dc_data_d  = io_mem_data;
                    end else begin
                        ic_valid_d = 1'b1;
                        ic_data_d  = io_mem_data;
                    end
                end else if (timeout_hit) begin
                    if (grant_dcache_q) begin
                        dc_valid_d = 1'b1;
                        dc_data_d  = '0;
                    end else begin
                        ic_valid_d = 1'b1;
                        ic_data_d  = '0;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    dc_error_d = grant_dcache_q;
                    ic_error_d = ~grant_dcache_q;
`endif
                end
            end
            ST_WRITE: begin
                if (i_mem_done) begin
                    dc_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    dc_valid_d = 1'b1;
                    dc_data_d  = '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    dc_error_d = 1'b1;
`endif
                end
            end
            default: begin
            end
        endcase
    end

    // Output and datapath registers; reset drops strobes and pulses at once.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            last_dcache_q  <= 1'b0;
            grant_dcache_q <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            ic_valid_q     <= 1'b0;
            ic_data_q      <= '0;
            dc_valid_q     <= 1'b0;
            dc_data_q      <= '0;
        end else begin
            last_dcache_q  <= last_dcache_d;
            grant_dcache_q <= grant_dcache_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            ic_valid_q     <= ic_valid_d;
            ic_data_q      <= ic_data_d;
            dc_valid_q     <= dc_valid_d;
            dc_data_q      <= dc_data_d;
        end
    end

    assign o_mem_address  = addr_q & ALIGN_MASK;
    assign o_mem_read     = mem_read_q;
    assign o_mem_write    = mem_write_q;
    assign io_mem_data    = mem_write_q ? wdata_q : {LINE_BITS{1'bz}};

    assign o_icache_valid = ic_valid_q;
    assign o_icache_data  = ic_data_q;
    assign o_dcache_valid = dc_valid_q;
    assign o_dcache_rdata = dc_data_q;

    assign o_debug_state  = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Bench for mem_arbiter with a small line RAM model (32 lines, byte at
// address a initialised to a[7:0]). Response ready/done are registered
// copies of the strobes, which gives the nominal capture two edges after grant.

module tb_mem_arbiter;

    localparam int LW = 256;
    localparam int TO = 64;

    typedef struct packed {
        logic        is_dc;
        logic        is_wr;
        logic [31:0] addr;
        logic [7:0]  wbyte;
        logic        exp_fill;
        logic [7:0]  exp_byte;
    } vec_t;

    logic          clock;
    logic          rst;
    logic          ic_req;
    logic [31:0]   ic_addr;
    logic          ic_valid;
    logic [LW-1:0] ic_data;
    logic          ic_error;
    logic          dc_req;
    logic          dc_write;
    logic [31:0]   dc_addr;
    logic [LW-1:0] dc_wdata;
    logic          dc_valid;
    logic [LW-1:0] dc_rdata;
    logic          dc_error;
    logic [31:0]   mem_address;
    logic          mem_read;
    logic          mem_write;
    wire  [LW-1:0] mem_bus;
    logic          mem_ready;
    logic          mem_done;
    logic [1:0]    dbg_state;

    // RAM model state
    logic [LW-1:0] ram [0:31];
    logic [LW-1:0] ram_q;
    logic          ram_ready;
    logic          ram_done;
    logic          ram_mute;
    logic          force_ready;

    // Scoreboard
    logic [LW-1:0] ic_exp_q[$];
    logic          ic_err_q[$];
    logic [LW-1:0] dc_exp_q[$];
    logic          dc_err_q[$];
    logic          dc_wr_q[$];
    logic          order_q[$];
    int            n_valid;
    int            checks;
    int            errors;
    logic          ic_prev;
    logic          dc_prev;

    vec_t          vecs [0:7];

    mem_arbiter dut (
        .i_clock          (clock),
        .i_reset          (rst),
        .i_icache_req     (ic_req),
        .i_icache_address (ic_addr),
        .o_icache_valid   (ic_valid),
        .o_icache_data    (ic_data),
        .o_icache_error   (ic_error),
        .i_dcache_req     (dc_req),
        .i_dcache_write   (dc_write),
        .i_dcache_address (dc_addr),
        .i_dcache_wdata   (dc_wdata),
        .o_dcache_valid   (dc_valid),
        .o_dcache_rdata   (dc_rdata),
        .o_dcache_error   (dc_error),
        .o_mem_address    (mem_address),
        .o_mem_read       (mem_read),
        .o_mem_write      (mem_write),
        .io_mem_data      (mem_bus),
        .i_mem_ready      (mem_ready),
        .i_mem_done       (mem_done),
        .o_debug_state    (dbg_state)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench time limit");
    end

    // RAM model
    assign mem_bus   = (ram_ready && !mem_write) ? ram_q : {LW{1'bz}};
    assign mem_ready = ram_ready | force_ready;
    assign mem_done  = ram_done;

    always @(posedge clock) begin
        ram_ready <= mem_read & ~ram_mute;
        ram_done  <= mem_write & ~ram_mute;
        if (mem_read) ram_q <= ram[mem_address[9:5]];
        if (mem_write && !ram_done && !ram_mute) ram[mem_address[9:5]] <= mem_bus;
    end

    function automatic logic [LW-1:0] fill_line(input logic [7:0] b);
        logic [LW-1:0] l;
        for (int i = 0; i < 32; i++) l[8*i +: 8] = b;
        return l;
    endfunction

    function automatic logic [LW-1:0] pat_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < 32; i++) l[8*i +: 8] = base[7:0] + 8'(i);
        return l;
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations when a valid pulse appears.
    always @(negedge clock) begin
        if (ic_valid) begin
            n_valid++;
            chk("ic_single_pulse", ic_prev, 0);
            if (ic_exp_q.size() == 0) begin
                chk("ic_unexpected_valid", ic_valid, 0);
            end else begin
                chk("ic_data", ic_data, ic_exp_q.pop_front());
                chk("ic_error", ic_error, ic_err_q.pop_front());
            end
            if (order_q.size() != 0) chk("grant_order", dc_valid, order_q.pop_front());
        end
        if (dc_valid) begin
            logic wr;
            logic [LW-1:0] e;
            n_valid++;
            chk("dc_single_pulse", dc_prev, 0);
            if (dc_exp_q.size() == 0) begin
                chk("dc_unexpected_valid", dc_valid, 0);
            end else begin
                e  = dc_exp_q.pop_front();
                wr = dc_wr_q.pop_front();
                if (!wr) chk("dc_rdata", dc_rdata, e);
                chk("dc_error", dc_error, dc_err_q.pop_front());
            end
            if (order_q.size() != 0) chk("grant_order", dc_valid, order_q.pop_front());
        end
        ic_prev = ic_valid;
        dc_prev = dc_valid;
    end

    // Driver: raise a request and push its expected response.
    task automatic issue(input logic is_dc, input logic is_wr, input logic [31:0] addr,
                         input logic [7:0] wbyte, input logic [LW-1:0] exp, input logic exp_err);
        if (is_dc) begin
            dc_req   = 1'b1;
            dc_write = is_wr;
            dc_addr  = addr;
            dc_wdata = fill_line(wbyte);
            dc_exp_q.push_back(exp);
            dc_wr_q.push_back(is_wr);
            dc_err_q.push_back(exp_err);
            order_q.push_back(1'b1);
        end else begin
            ic_req  = 1'b1;
            ic_addr = addr;
            ic_exp_q.push_back(exp);
            ic_err_q.push_back(exp_err);
            order_q.push_back(1'b0);
        end
    endtask

    task automatic wait_strobe(input int bound, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clock);
            seen = mem_read | mem_write;
        end
    endtask

    // Counts strobe-high samples from the current cycle until the valid pulse.
    task automatic wait_valid(input logic is_dc, input int bound, output bit seen, output int hi);
        seen = 1'b0;
        hi   = 0;
        for (int c = 0; c < bound && !seen; c++) begin
            if (mem_read | mem_write) hi++;
            @(negedge clock);
            seen = is_dc ? dc_valid : ic_valid;
        end
    endtask

    task automatic check_reset_state();
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_ic_valid", ic_valid, 0);
        chk("rst_dc_valid", dc_valid, 0);
        chk("rst_ic_error", ic_error, 0);
        chk("rst_dc_error", dc_error, 0);
        chk("rst_ic_data", ic_data, 0);
        chk("rst_dc_rdata", dc_rdata, 0);
        chk("rst_state", dbg_state, 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [LW-1:0] exp;
        bit seen;
        int hi;
        exp = v.exp_fill ? fill_line(v.exp_byte) : pat_line(v.addr & ~32'h1F);
        @(negedge clock);
        issue(v.is_dc, v.is_wr, v.addr, v.wbyte, exp, 1'b0);
        wait_strobe(20, seen);
        chk("vec_strobe_seen", seen, 1);
        if (seen) begin
            chk("vec_mem_address", mem_address, v.addr & ~32'h1F);
            chk("vec_mem_write", mem_write, v.is_wr);
            chk("vec_mem_read", mem_read, !v.is_wr);
        end
        wait_valid(v.is_dc, 20, seen, hi);
        chk("vec_valid_seen", seen, 1);
        chk("vec_strobe_cycles", hi, 2);
        if (v.is_dc) dc_req = 1'b0; else ic_req = 1'b0;
    endtask

    initial begin
        bit seen;
        int hi;
        int base;
        int cnt;
        bit st_ok;

        checks = 0; errors = 0; n_valid = 0;
        ic_prev = 1'b0; dc_prev = 1'b0;
        rst = 1'b0; ic_req = 1'b0; ic_addr = '0;
        dc_req = 1'b0; dc_write = 1'b0; dc_addr = '0; dc_wdata = '0;
        ram_mute = 1'b0; force_ready = 1'b0;
        ram_ready = 1'b0; ram_done = 1'b0; ram_q = '0;
        for (int k = 0; k < 32; k++) ram[k] = pat_line(32'(k) << 5);

        vecs[0] = '{is_dc:1'b0, is_wr:1'b0, addr:32'h047, wbyte:8'h00, exp_fill:1'b0, exp_byte:8'h00};
        vecs[1] = '{is_dc:1'b1, is_wr:1'b1, addr:32'h100, wbyte:8'hA5, exp_fill:1'b0, exp_byte:8'h00};
        vecs[2] = '{is_dc:1'b1, is_wr:1'b0, addr:32'h100, wbyte:8'h00, exp_fill:1'b1, exp_byte:8'hA5};
        vecs[3] = '{is_dc:1'b0, is_wr:1'b0, addr:32'h3E0, wbyte:8'h00, exp_fill:1'b0, exp_byte:8'h00};
        vecs[4] = '{is_dc:1'b1, is_wr:1'b0, addr:32'h01F, wbyte:8'h00, exp_fill:1'b0, exp_byte:8'h00};
        vecs[5] = '{is_dc:1'b1, is_wr:1'b1, addr:32'h2C0, wbyte:8'h3C, exp_fill:1'b0, exp_byte:8'h00};
        vecs[6] = '{is_dc:1'b0, is_wr:1'b0, addr:32'h2D5, wbyte:8'h00, exp_fill:1'b1, exp_byte:8'h3C};
        vecs[7] = '{is_dc:1'b1, is_wr:1'b0, addr:32'h10A, wbyte:8'h00, exp_fill:1'b1, exp_byte:8'hA5};

        // Reset
        repeat (3) @(negedge clock);
        check_reset_state();
        rst = 1'b1;

        // Table-driven single-requester transactions
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during READ: strobe drops at once, no valid, then normal service
        @(negedge clock);
        ic_req  = 1'b1;
        ic_addr = 32'h80;
        wait_strobe(20, seen);
        chk("rstmid_read_started", mem_read, 1);
        #2 rst = 1'b0;
        #1 chk("rstmid_read_drop", mem_read, 0);
        chk("rstmid_state", dbg_state, 0);
        repeat (2) @(negedge clock);
        rst = 1'b1;
        issue(1'b0, 1'b0, 32'h80, 8'h00, pat_line(32'h80), 1'b0);
        wait_strobe(20, seen);
        chk("rstmid_restart", seen, 1);
        wait_valid(1'b0, 20, seen, hi);
        chk("rstmid_valid", seen, 1);
        ic_req = 1'b0;

        // Stale ready held high keeps the arbiter in RELEASE
        @(negedge clock);
        issue(1'b0, 1'b0, 32'h20, 8'h00, pat_line(32'h20), 1'b0);
        wait_strobe(20, seen);
        wait_valid(1'b0, 20, seen, hi);
        chk("hold_first_valid", seen, 1);
        force_ready = 1'b1;
        issue(1'b0, 1'b0, 32'h20, 8'h00, pat_line(32'h20), 1'b0);
        cnt = 0;
        st_ok = 1'b1;
        repeat (10) begin
            @(negedge clock);
            if (mem_read | mem_write) cnt++;
            if (dbg_state != 2'd3) st_ok = 1'b0;
        end
        chk("hold_no_grant", cnt, 0);
        chk("hold_in_release", st_ok, 1);
        force_ready = 1'b0;
        wait_strobe(10, seen);
        chk("hold_regrant", seen, 1);
        wait_valid(1'b0, 20, seen, hi);
        chk("hold_second_valid", seen, 1);
        ic_req = 1'b0;

        // Tie from reset: dcache, icache, dcache, icache
        @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        check_reset_state();
        issue(1'b1, 1'b0, 32'h200, 8'h00, pat_line(32'h200), 1'b0);
        issue(1'b0, 1'b0, 32'h060, 8'h00, pat_line(32'h060), 1'b0);
        issue(1'b1, 1'b0, 32'h200, 8'h00, pat_line(32'h200), 1'b0);
        issue(1'b0, 1'b0, 32'h060, 8'h00, pat_line(32'h060), 1'b0);
        @(negedge clock);
        rst  = 1'b1;
        base = n_valid;
        for (int c = 0; c < 200 && n_valid < base + 4; c++) @(negedge clock);
        chk("tie_four_valids", n_valid - base, 4);
        ic_req = 1'b0;
        dc_req = 1'b0;
        repeat (8) @(negedge clock);
        chk("tie_no_extra", n_valid - base, 4);

        // RAM never answers
        @(negedge clock);
        ram_mute = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        issue(1'b0, 1'b0, 32'h40, 8'h00, '0, 1'b1);
        wait_strobe(20, seen);
        chk("mute_strobe", seen, 1);
        wait_valid(1'b0, TO + 20, seen, hi);
        chk("timeout_valid", seen, 1);
        chk("timeout_cycles", hi, TO);
        ic_req = 1'b0;
        @(negedge clock);
        chk("timeout_strobe_low", mem_read, 0);
`else
        ic_req  = 1'b1;
        ic_addr = 32'h40;
        wait_strobe(20, seen);
        chk("mute_strobe", seen, 1);
        base = n_valid;
        repeat (100) @(negedge clock);
        chk("hang_strobe_high", mem_read, 1);
        chk("hang_no_valid", n_valid - base, 0);
`endif
        ram_mute = 1'b0;
        @(negedge clock);
        rst    = 1'b0;
        ic_req = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        repeat (4) @(negedge clock);

        chk("queues_drained", ic_exp_q.size() + dc_exp_q.size() + order_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester line arbiter upstream of the RAM model, sole master of the memory bus (address/read/write/data/ready/done). Takes line reads from the instruction cache and line reads/writes from the data cache. Arbitrates round-robin, drives one 256-bit bus transaction at a time and returns one-cycle response pulses. Sequences the RAM level handshake, including waiting for ready/done to fall before the next transaction.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_BITS, 256, line/data bus width (32 bytes)
TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_ARB_TIMEOUT_EN

Ports:
i_clock  in  1  clock
i_reset  in  1  reset, asynchronous, active-low (0 = reset)
i_icache_req  in  1  icache line read request; hold until o_icache_valid
i_icache_address  in  32  icache byte address
o_icache_valid  out  1  one-cycle pulse, o_icache_data valid
o_icache_data  out  256  returned line
o_icache_error  out  1  qualifies o_icache_valid: transaction timed out
i_dcache_req  in  1  dcache request; hold until o_dcache_valid
i_dcache_write  in  1  1 = write line, 0 = read line; stable while req high
i_dcache_address  in  32  dcache byte address
i_dcache_wdata  in  256  write line; stable while req high
o_dcache_valid  out  1  one-cycle pulse: read data valid or write complete
o_dcache_rdata  out  256  returned line (reads only)
o_dcache_error  out  1  qualifies o_dcache_valid: timeout
o_mem_address  out  32  bus address, {addr[31:5], 5'h0}
o_mem_read  out  1  bus read strobe
o_mem_write  out  1  bus write strobe
io_mem_data  inout  256  bus data; driven only while o_mem_write=1, else 'z
i_mem_ready  in  1  RAM read data valid
i_mem_done  in  1  RAM write complete

Behaviour:
- States: IDLE, READ, WRITE, RELEASE. All outputs registered.
- Reset (i_reset=0, async): state=IDLE; o_mem_read/o_mem_write/all valid/error=0; o_mem_address=0; data outputs=0; io_mem_data='z; last-grant pointer=ICACHE.
- IDLE: sample requests at edge E0. If only one is high, grant it. If both are high, grant the one not last granted, so the first tie after reset goes to dcache. Update the pointer. Latch address, direction and wdata. Go to READ (icache or dcache read) or WRITE; o_mem_read or o_mem_write rises after E0.
- READ: hold o_mem_read. On a sampled i_mem_ready=1, capture io_mem_data into the granted requester's data register, pulse its valid for one cycle, drop o_mem_read and go to RELEASE. Nominal: RAM ready after E1, capture at E2, valid during the cycle after E2.
- WRITE: drive io_mem_data with latched wdata and hold o_mem_write. On a sampled i_mem_done=1, drop o_mem_write, release io_mem_data to 'z, pulse o_dcache_valid and go to RELEASE.
- RELEASE: no strobes. Return to IDLE on the first edge where i_mem_ready=0 and i_mem_done=0. Prevents a stale ready/done being taken as the next response.
- Request seen in IDLE is granted at that edge. Minimum spacing between grants is 5 cycles with the RAM model.
- A requester must not drop req before its valid. Req still high in the cycle after valid is a new request.
- i_mem_ready/i_mem_done are ignored outside their own state.
- Ungranted requests wait; no starvation, since round-robin guarantees a grant within one transaction.
- Reset mid-transaction: strobes drop immediately, bus released, no valid pulse for the aborted request.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined: counter cleared on entry to READ/WRITE, increments each cycle there. When it reaches TIMEOUT_CYCLES without ready/done, drop strobes and release the bus. Pulse valid with error=1 (data outputs 0), then go to RELEASE.
- Undefined: no counter; READ/WRITE wait indefinitely; o_icache_error/o_dcache_error tied 0.

Test Plan:
- Reset release, icache req addr 0x0000_0047 -> o_mem_address=0x0000_0040, o_mem_read after E0, o_icache_valid in the cycle after E2 with RAM bytes 0x40..0x5F, error=0.
- dcache write addr 0x100, wdata pattern 0xA5 bytes -> o_mem_write 2 cycles, io_mem_data driven then 'z, o_dcache_valid one pulse; a following dcache read of 0x100 returns the 0xA5 line.
- Both req high from reset, held -> grants dcache, icache, dcache, icache; each valid exactly one pulse.
- Assert i_reset=0 while in READ -> o_mem_read=0 asynchronously, no valid; after release the icache req held high is served normally.
- Hold i_mem_ready=1 artificially after a read -> FSM stays in RELEASE, no new grant until ready=0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, RAM never responds -> valid+error after 8 cycles in READ, strobes low; without the macro, strobe stays high and no valid.
